// File: rtl/note_sequencer_pkg.sv
// Shared definitions for the note sequencer.
//   state_t        : FSM state encoding (IDLE, FETCH, LOAD, PLAY, GAP)
//   DIV_W_DEF      : default width of the half-period divider field of a song entry
//   DUR_W_DEF      : default width of the duration field (beat ticks) of a song entry
//   END_DUR        : duration value that marks the end of the song
//   MIN_TONE_DIV   : divider values below this are rests
// A song entry is packed as {div, dur}.
package note_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_PLAY  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  localparam int DIV_W_DEF    = 20;
  localparam int DUR_W_DEF    = 8;
  localparam int END_DUR      = 0;
  localparam int MIN_TONE_DIV = 2;

  function automatic logic is_rest(input logic [31:0] div);
    return div < 32'(MIN_TONE_DIV);
  endfunction

  function automatic logic is_end(input logic [31:0] dur);
    return dur == 32'(END_DUR);
  endfunction

endpackage

// File: rtl/note_sequencer_song_rom.sv
// song_rom: synchronous-read song storage, one-cycle read latency.
//   clk  : clock
//   addr : entry index, sampled on the rising edge
//   div  : half-period divider of the addressed entry (valid one cycle later)
//   dur  : duration in beat ticks of the addressed entry (valid one cycle later)
// Contents come from SONG_INIT, a packed image of the song's memory file with
// entry i at bits [i*(DIV_W+DUR_W) +: DIV_W+DUR_W], each entry {div, dur}.
module song_rom
  import note_sequencer_pkg::*;
#(
  parameter int SONG_LEN = 16,
  parameter int DIV_W    = DIV_W_DEF,
  parameter int DUR_W    = DUR_W_DEF,
  parameter logic [SONG_LEN*(DIV_W+DUR_W)-1:0] SONG_INIT = '0
) (
  input  logic                        clk,
  input  logic [$clog2(SONG_LEN)-1:0] addr,
  output logic [DIV_W-1:0]            div,
  output logic [DUR_W-1:0]            dur
);

  localparam int EW = DIV_W + DUR_W;

  logic [EW-1:0] mem [SONG_LEN];
  logic [EW-1:0] q;

  for (genvar i = 0; i < SONG_LEN; i++) begin : g_ent
    assign mem[i] = SONG_INIT[i*EW +: EW];
  end

  always_ff @(posedge clk) q <= mem[addr];

  assign {div, dur} = q;

endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: plays a song from song_rom as square waves.
//   clk      : clock, all state changes on the rising edge
//   rst_n    : asynchronous active-low reset
//   start    : pulse, begins playback from entry 0 (ignored while busy)
//   stop     : level, aborts playback (wins over start)
//   loop_en  : restart the song after its end (sampled at the end decision)
//   tone     : {gate, octave down, octave up, base} registered square waves
//   busy     : high whenever the FSM is not idle
//   note_idx : index of the current song entry
module note_sequencer
  import note_sequencer_pkg::*;
#(
  parameter int SONG_LEN  = 16,
  parameter int DIV_W     = DIV_W_DEF,
  parameter int DUR_W     = DUR_W_DEF,
  parameter int TICK_DIV  = 500000,
  parameter int GAP_TICKS = 1,
  parameter logic [SONG_LEN*(DIV_W+DUR_W)-1:0] SONG_INIT = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        loop_en,
  output logic [3:0]                  tone,
  output logic                        busy,
  output logic [$clog2(SONG_LEN)-1:0] note_idx
);

  localparam int AW = $clog2(SONG_LEN);
  localparam int TW = $clog2(TICK_DIV);
  localparam int GW = $clog2(GAP_TICKS + 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(SONG_LEN - 1);

  state_t            state, state_nx;
  logic [AW-1:0]     idx;
  logic [TW-1:0]     tick_cnt;
  logic              tick;
  logic [GW-1:0]     gap_cnt;
  logic              gap_done;
  logic [DIV_W-1:0]  rom_div, div_q, half, hp0, hp1;
  logic [DUR_W-1:0]  rom_dur, dur_rem;

  song_rom #(
    .SONG_LEN (SONG_LEN),
    .DIV_W    (DIV_W),
    .DUR_W    (DUR_W),
    .SONG_INIT(SONG_INIT)
  ) u_rom (
    .clk (clk),
    .addr(idx),
    .div (rom_div),
    .dur (rom_dur)
  );

  // Beat tick runs from the start pulse onwards and is never realigned to
  // note boundaries, so note lengths are measured in whole ticks of one grid.
  assign tick     = (state != S_IDLE) && (tick_cnt == TW'(TICK_DIV - 1));
  assign gap_done = tick && (gap_cnt == GW'(GAP_TICKS - 1));
  assign half     = div_q >> 1;
  assign busy     = (state != S_IDLE);
  assign note_idx = idx;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_FETCH;
      S_FETCH: state_nx = S_LOAD;
      S_LOAD: begin
        if (is_end(32'(rom_dur))) state_nx = loop_en ? S_FETCH : S_IDLE;
        else                      state_nx = S_PLAY;
      end
      S_PLAY:  if (tick && dur_rem == DUR_W'(1)) state_nx = S_GAP;
      S_GAP: begin
        if (gap_done) state_nx = (idx == LAST_IDX && !loop_en) ? S_IDLE : S_FETCH;
      end
      default: state_nx = S_IDLE;
    endcase
    if (stop) state_nx = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      idx      <= '0;
      tick_cnt <= '0;
      gap_cnt  <= '0;
      div_q    <= '0;
      dur_rem  <= '0;
    end else begin
      state    <= state_nx;
      tick_cnt <= (state == S_IDLE || tick) ? '0 : tick_cnt + TW'(1);
      case (state)
        S_IDLE: idx <= '0;
        S_LOAD: begin
          div_q   <= rom_div;
          dur_rem <= rom_dur;
          if (is_end(32'(rom_dur))) idx <= '0;
        end
        S_PLAY: begin
          gap_cnt <= '0;
          if (tick) dur_rem <= dur_rem - DUR_W'(1);
        end
        S_GAP: begin
          if (gap_done) begin
            gap_cnt <= '0;
            idx     <= (idx == LAST_IDX) ? '0 : idx + AW'(1);
          end else if (tick) begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Tone outputs are driven from the next state so they are already correct
  // in the first PLAY cycle and already silent in the first non-PLAY cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tone <= '0;
      hp0  <= '0;
      hp1  <= '0;
    end else if (state_nx != S_PLAY) begin
      tone <= '0;
      hp0  <= '0;
      hp1  <= '0;
    end else if (state == S_LOAD) begin
      tone <= {~is_rest(32'(rom_div)), 3'b000};
      hp0  <= '0;
      hp1  <= '0;
    end else if (!is_rest(32'(div_q))) begin
      if (hp0 == div_q - DIV_W'(1)) begin
        hp0     <= '0;
        tone[0] <= ~tone[0];
        if (!tone[0]) tone[2] <= ~tone[2];  // rising edge of the base tone
      end else begin
        hp0 <= hp0 + DIV_W'(1);
      end
      if (hp1 == half - DIV_W'(1)) begin
        hp1     <= '0;
        tone[1] <= ~tone[1];
      end else begin
        hp1 <= hp1 + DIV_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
module tb_note_sequencer;

  localparam int T    = 4;
  localparam int GAPT = 1;
  localparam int NC   = 72;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       stop = 1'b0, loop_en = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic [3:0] tone1, tone2;
  logic       busy1, busy2;
  logic [1:0] idx1;
  logic [0:0] idx2;

  always #5 clk = ~clk;

  note_sequencer #(
    .SONG_LEN(4), .DIV_W(8), .DUR_W(4), .TICK_DIV(T), .GAP_TICKS(GAPT),
    .SONG_INIT({12'h000, 8'd3, 4'd1, 8'd0, 4'd1, 8'd5, 4'd2})
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .stop(stop), .loop_en(loop_en),
    .tone(tone1), .busy(busy1), .note_idx(idx1)
  );

  // Second song without an end marker exercises the last-index wrap.
  note_sequencer #(
    .SONG_LEN(2), .DIV_W(8), .DUR_W(4), .TICK_DIV(T), .GAP_TICKS(GAPT),
    .SONG_INIT({8'd4, 4'd1, 8'd2, 4'd1})
  ) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .stop(stop), .loop_en(loop_en),
    .tone(tone2), .busy(busy2), .note_idx(idx2)
  );

  int tests = 0, fails = 0;
  int sdiv [2][4] = '{'{5, 0, 3, 0}, '{2, 4, 0, 0}};
  int sdur [2][4] = '{'{2, 1, 1, 0}, '{1, 1, 0, 0}};
  int slen [2]    = '{4, 2};
  int         ebusy [2][NC];
  int         eidx  [2][NC];
  logic [3:0] etone [2][NC];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // First cycle >= c on which a beat tick fires, plus k-1 further ticks.
  function automatic int nth_tick(input int c, input int k);
    return c + (T - 1 - c % T) + (k - 1) * T;
  endfunction

  // Tone bits j cycles into a note with divider dv.
  function automatic logic [3:0] play_tone(input int dv, input int j);
    if (dv < 2) return 4'b0000;
    return {1'b1, 1'(((j + dv) / (2 * dv)) % 2), 1'((j / (dv / 2)) % 2), 1'((j / dv) % 2)};
  endfunction

  task automatic mark(input int d, input int a, input int b, input int ix, input int dv, input bit play);
    for (int n = a; n <= b && n < NC; n++) begin
      ebusy[d][n] = 1;
      eidx[d][n]  = ix;
      etone[d][n] = play ? play_tone(dv, n - a) : 4'b0000;
    end
  endtask

  // Expected per-cycle outputs, cycle 0 being the first cycle after the start edge.
  task automatic build(input int d, input bit lp, input int stop_at);
    int pos, ix, l, g;
    for (int n = 0; n < NC; n++) begin
      ebusy[d][n] = 0; eidx[d][n] = 0; etone[d][n] = 4'b0000;
    end
    pos = 0; ix = 0;
    while (pos < NC) begin
      mark(d, pos, pos + 1, ix, 0, 1'b0);            // fetch + load
      if (sdur[d][ix] == 0) begin
        if (!lp) break;
        ix = 0; pos += 2;
        continue;
      end
      l = nth_tick(pos + 2, sdur[d][ix]);
      mark(d, pos + 2, l, ix, sdiv[d][ix], 1'b1);    // play
      g = nth_tick(l + 1, GAPT);
      mark(d, l + 1, g, ix, 0, 1'b0);                // gap
      pos = g + 1;
      if (ix == slen[d] - 1) begin
        if (!lp) break;
        ix = 0;
      end else ix++;
    end
    if (stop_at >= 0)
      for (int n = stop_at + 1; n < NC; n++) begin
        ebusy[d][n] = 0; etone[d][n] = 4'b0000;
      end
  endtask

  task automatic check_cycle(input int n);
    chk($sformatf("busy1@%0d", n), 32'(busy1), 32'(ebusy[0][n]));
    chk($sformatf("tone1@%0d", n), 32'(tone1), 32'(etone[0][n]));
    chk($sformatf("busy2@%0d", n), 32'(busy2), 32'(ebusy[1][n]));
    chk($sformatf("tone2@%0d", n), 32'(tone2), 32'(etone[1][n]));
    if (ebusy[0][n] != 0) chk($sformatf("idx1@%0d", n), 32'(idx1), 32'(eidx[0][n]));
    if (ebusy[1][n] != 0) chk($sformatf("idx2@%0d", n), 32'(idx2), 32'(eidx[1][n]));
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy1"}, 32'(busy1), 32'(0));
    chk({tag, "_busy2"}, 32'(busy2), 32'(0));
    chk({tag, "_tone1"}, 32'(tone1), 32'(0));
    chk({tag, "_tone2"}, 32'(tone2), 32'(0));
  endtask

  // Entered at posedge+1 with both DUTs idle; leaves them idle at posedge+1.
  task automatic run(input bit lp, input int stop_at, input int sp);
    build(0, lp, stop_at);
    build(1, lp, stop_at);
    loop_en = lp; start1 = 1'b1; start2 = 1'b1;
    @(posedge clk); #1;
    for (int n = 0; n < NC; n++) begin
      stop   = (n == stop_at);
      start1 = (n == sp) && (ebusy[0][n] != 0);
      start2 = (n == sp) && (ebusy[1][n] != 0);
      @(negedge clk);
      check_cycle(n);
      @(posedge clk); #1;
    end
    stop = 1'b1; start1 = 1'b0; start2 = 1'b0;
    @(posedge clk); #1;
    stop = 1'b0;
    @(negedge clk);
    check_idle("after_stop");
    @(posedge clk); #1;
  endtask

  initial begin
    int sa;
    // reset state
    #12;
    check_idle("reset");
    chk("reset_idx1", 32'(idx1), 32'(0));
    chk("reset_idx2", 32'(idx2), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_idle("post_reset");
      @(posedge clk); #1;
    end

    run(1'b0, -1, -1);     // single pass, end marker -> idle
    run(1'b1, -1, 6);      // looping, start pulse during play ignored
    run(1'b0, 4, -1);      // stop mid-play of entry 0
    run(1'b0, -1, -1);     // replays from entry 0 after the stop

    // start and stop together while idle
    start1 = 1'b1; start2 = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start2 = 1'b0; stop = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_idle("start_stop");
      @(posedge clk); #1;
    end

    // asynchronous reset in the middle of a note
    build(0, 1'b1, -1);
    loop_en = 1'b1; start1 = 1'b1; start2 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start2 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_tone1", 32'(tone1), 32'(etone[0][4]));
    #1 rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    chk("async_rst_idx1", 32'(idx1), 32'(0));
    chk("async_rst_idx2", 32'(idx2), 32'(0));
    @(negedge clk); #1;
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_idle("rst_release");
      chk("rst_release_idx1", 32'(idx1), 32'(0));
    end
    @(posedge clk); #1;
    run(1'b0, -1, -1);

    // randomized playback: loop mode, stop point and stray start pulse
    repeat (8) begin
      sa = int'($urandom_range(0, 40));
      if ($urandom % 3 == 0) sa = -1;
      run(1'($urandom % 2), sa, int'($urandom_range(0, NC - 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 SHALL have parameter SONG_LEN, default 16; number of note entries in the song ROM, at least 2.
REQ-002 SHALL have parameter DIV_W, default 20; width of the half-period divider field.
REQ-003 SHALL have parameter DUR_W, default 8; width of the duration field, in beat ticks.
REQ-004 SHALL have parameter TICK_DIV, default 500000; clk cycles per beat tick.
REQ-005 SHALL have parameter GAP_TICKS, default 1; silent beat ticks between notes.
REQ-006 SHALL have port clk  in  1; the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst_n  in  1; reset, asynchronous and active-low.
REQ-008 SHALL have port start  in  1; pulse that begins playback from entry 0.
REQ-009 SHALL have port stop  in  1; level that aborts playback.
REQ-010 SHALL have port loop_en  in  1; when high, the song restarts after the end.
REQ-011 SHALL have port tone  out  4; square-wave bus for the downstream player's in_wires.
REQ-012 SHALL have port busy  out  1; high in every state except IDLE.
REQ-013 SHALL have port note_idx  out  clog2(SONG_LEN); index of the current entry.

Function
REQ-014 ROM entry SHALL be {div[DIV_W-1:0], dur[DUR_W-1:0]}; div<2 means rest; dur==0 means end-of-song marker.
REQ-015 FSM states SHALL be IDLE, FETCH, LOAD, PLAY, GAP.
REQ-016 IDLE: start=1 and stop=0 -> FETCH, with note_idx=0 and the tick counter cleared.
REQ-017 FETCH SHALL present note_idx to the synchronous ROM, which has 1-cycle read latency, then go to LOAD.
REQ-018 LOAD SHALL latch div and dur and clear the half-period counter.
REQ-019 LOAD with dur==0 SHALL go to FETCH with idx=0 if loop_en=1, else to IDLE.
REQ-020 LOAD with dur!=0 SHALL go to PLAY.
REQ-021 Beat tick SHALL be a 1-cycle strobe every TICK_DIV clocks, free-running while busy.
REQ-022 PLAY SHALL decrement the remaining duration on each tick; on the tick at which remaining==1 it SHALL go to GAP.
REQ-023 GAP SHALL hold tone=0 for GAP_TICKS ticks, then advance idx.
REQ-024 Advance at idx==SONG_LEN-1 SHALL wrap to 0 if loop_en=1, else go to IDLE; otherwise idx+1 -> FETCH.
REQ-025 tone[0] SHALL toggle when the half-period counter reaches div-1; the counter then resets to 0. Period = 2*div clocks.
REQ-026 tone[1] SHALL be an octave up, with its own counter at div>>1.
REQ-027 tone[2] SHALL be an octave down: it toggles on each rising edge of tone[0].
REQ-028 tone[3] SHALL be the gate: 1 in PLAY when div>=2, else 0.
REQ-029 All tone bits SHALL be 0 outside PLAY and during rests; all are registered outputs.
REQ-030 stop=1 in any state SHALL force IDLE on the next edge, with tone=0 and busy=0.
REQ-031 start and stop high together SHALL give precedence to stop.
REQ-032 start while busy SHALL be ignored.
REQ-033 loop_en SHALL be sampled only at the end-of-song decision.
REQ-034 Counters SHALL be unsigned; the half-period counter is DIV_W bits wide and the tick counter is clog2(TICK_DIV) bits wide; neither overflows, because each compares before incrementing.

Reset
REQ-035 rst_n=0 SHALL asynchronously set: state=IDLE, tone=4'b0000, busy=0, note_idx=0, all counters 0, latched div/dur 0.
REQ-036 Deassertion SHALL take effect at the next clk edge; no playback until a start pulse arrives.
REQ-037 Reset mid-note SHALL silence tone within reset assertion, without waiting for a clock.

Structure
REQ-038 Shared package SHALL hold the FSM state encoding, the ROM entry field widths, and the end-of-song and rest encodings.
REQ-039 Song storage SHALL be the sub-module song_rom: synchronous read, initialised from a memory file, parameterised by SONG_LEN, DIV_W and DUR_W.
REQ-040 Top level SHALL contain the FSM, tick divider, three tone dividers and output registers; target size 120-400 lines.

Verification
Bench parameters for all scenarios: TICK_DIV=4, GAP_TICKS=1; ROM = {(div=5, dur=2), (div=0, dur=1), (div=3, dur=1), (0, 0)}.
REQ-041 start pulse, loop_en=0 -> FETCH, LOAD, PLAY: tone[0] period 10 clocks for 2 ticks; gap; rest with tone=0000 and tone[3]=0; tone[0] period 6 clocks; end marker -> IDLE, busy=0.
REQ-042 Same stimulus, loop_en=1 -> after the end marker note_idx returns to 0 and the div=5 note replays; busy stays 1.
REQ-043 stop asserted mid-PLAY of entry 0 -> next edge tone=0000, busy=0, state IDLE; later start replays from idx 0.
REQ-044 start and stop high in the same cycle in IDLE -> remains IDLE, busy=0; start pulse during PLAY -> no restart, note_idx unchanged.
REQ-045 rst_n pulled low between clock edges during PLAY -> tone=0000 and note_idx=0 immediately; after release, outputs stay idle until a start pulse.
REQ-046 Check div=5: tone[1] period 4 clocks (div>>1=2), tone[2] period 20 clocks, tone[3]=1 throughout PLAY.
